// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
// md_pkg : ALU control codes, multiply/divide op encodings and sequencer state
// Revision: 1.0
// ============================================================================
package md_pkg;

    // Shared with the EX-stage ALU decoder
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] MD_MUL  = 2'b00;
    localparam logic [1:0] MD_DIVU = 2'b01;
    localparam logic [1:0] MD_REMU = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } md_state_e;

endpackage
`default_nettype wire

// File: rtl/alu_md_seq_if.sv
`default_nettype none
// ============================================================================
// alu_md_seq_if : request handshake plus shared-ALU operand/result bundle
// Revision: 1.0
// ============================================================================
interface alu_md_seq_if #(
    parameter int XLEN = 64
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [3:0]      alu_ctrl;
    logic [XLEN-1:0] alu_y;

    // Pipeline side: issues requests and owns the ALU
    modport master (
        output start, op, a, b, alu_y,
        input  busy, done, result, alu_a, alu_b, alu_ctrl
    );

    // Sequencer side
    modport slave (
        input  start, op, a, b, alu_y,
        output busy, done, result, alu_a, alu_b, alu_ctrl
    );
endinterface
`default_nettype wire

// File: rtl/alu_md_seq.sv
`default_nettype none
// ============================================================================
// alu_md_seq : multi-cycle unsigned MUL/DIVU/REMU driving the shared ALU
// Revision: 1.0
// ============================================================================
module alu_md_seq
    import md_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = 6
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    alu_md_seq_if.slave  bus
);

    md_state_e       state;
    md_state_e       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [1:0]      op_q;
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplier;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] divisor;
    logic [XLEN-1:0] result_q;

    logic            is_mul;
    logic            last;
    logic            short_cut;
    logic            hi;
    logic            take;
    logic [XLEN-1:0] rem_sh;
    logic [XLEN-1:0] acc_nxt;
    logic [XLEN-1:0] rem_nxt;
    logic [XLEN-1:0] quo_nxt;
    logic [XLEN-1:0] short_res;
    logic [XLEN-1:0] final_res;

    always_comb begin
        is_mul    = (op_q == MD_MUL);
        last      = (cnt == CNT_W'(XLEN - 1));
        short_cut = (((bus.op == MD_DIVU) || (bus.op == MD_REMU)) && (bus.b == '0))
                    || (bus.op == 2'b11);
        rem_sh    = {rem[XLEN-2:0], quo[XLEN-1]};
        hi        = rem[XLEN-1];
        // A set hi bit means rem_sh is really >= 2^XLEN, so it always exceeds the divisor
        take      = hi | (rem_sh >= divisor);
        acc_nxt   = mplier[0] ? bus.alu_y : acc;
        rem_nxt   = take ? bus.alu_y : rem_sh;
        quo_nxt   = {quo[XLEN-2:0], take};
        case (bus.op)
            MD_DIVU: short_res = '1;
            MD_REMU: short_res = bus.a;
            default: short_res = '0;
        endcase
        if (is_mul)
            final_res = acc_nxt;
        else if (op_q == MD_DIVU)
            final_res = quo_nxt;
        else
            final_res = rem_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = short_cut ? DONE : RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        bus.alu_a    = '0;
        bus.alu_b    = '0;
        bus.alu_ctrl = ALU_ADD;
        case (state)
            RUN: begin
                bus.busy = 1'b1;
                if (is_mul) begin
                    bus.alu_a    = acc;
                    bus.alu_b    = mcand;
                    bus.alu_ctrl = ALU_ADD;
                end else begin
                    bus.alu_a    = rem_sh;
                    bus.alu_b    = divisor;
                    bus.alu_ctrl = ALU_SUB;
                end
            end
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            op_q     <= MD_MUL;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            rem      <= '0;
            quo      <= '0;
            divisor  <= '0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q    <= bus.op;
                        cnt     <= '0;
                        acc     <= '0;
                        mcand   <= bus.a;
                        mplier  <= bus.b;
                        rem     <= '0;
                        quo     <= bus.a;
                        divisor <= bus.b;
                        if (short_cut)
                            result_q <= short_res;
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (is_mul) begin
                        acc    <= acc_nxt;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                    end else begin
                        rem <= rem_nxt;
                        quo <= quo_nxt;
                    end
                    if (last)
                        result_q <= final_res;
                end
                default: ;
            endcase
        end
    end

    assign bus.result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_md_seq.sv
`default_nettype none
// ============================================================================
// tb_alu_md_seq : vector table + scoreboard bench for alu_md_seq
// Revision: 1.0
// ============================================================================
module tb_alu_md_seq;
    import md_pkg::*;

    localparam int XLEN = 64;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_md_seq_if #(.XLEN(XLEN)) bus ();

    // Behavioural stand-in for the pipeline's shared ALU
    assign bus.alu_y = (bus.alu_ctrl == ALU_SUB) ? (bus.alu_a - bus.alu_b)
                                                 : (bus.alu_a + bus.alu_b);

    alu_md_seq #(.XLEN(XLEN), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        bit          short_op;
    } vec_t;

    vec_t        vecs[10];
    logic [63:0] exp_q[$];
    int          nvec = 0;
    int          nerr = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp, input bit short_op, input int glitch_at);
        int          edges;
        int          busy_cnt;
        logic [63:0] e;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        exp_q.push_back(exp);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = {$urandom, $urandom};
        bus.b     = {$urandom, $urandom};
        if (!short_op) begin
            check("first iter alu_ctrl", {60'd0, bus.alu_ctrl},
                  {60'd0, (op == MD_MUL) ? ALU_ADD : ALU_SUB});
            check("first iter alu_b", bus.alu_b, (op == MD_MUL) ? a : b);
        end
        edges    = 0;
        busy_cnt = 0;
        while (!bus.done && edges < 200) begin
            if (bus.busy) busy_cnt++;
            if (edges == glitch_at) begin
                bus.start = 1'b1;
                bus.op    = MD_DIVU;
                bus.a     = 64'd100;
                bus.b     = 64'd7;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        bus.start = 1'b0;
        e = exp_q.pop_front();
        if (!bus.done) begin
            check("done timeout", {63'd0, bus.done}, 64'd1);
            return;
        end
        check("result", bus.result, e);
        check("latency edges", 64'(edges), short_op ? 64'd0 : 64'd64);
        check("busy cycles", 64'(busy_cnt), short_op ? 64'd0 : 64'd64);
        check("busy at done", {63'd0, bus.busy}, 64'd0);
        @(negedge clk);
        check("done pulse width", {63'd0, bus.done}, 64'd0);
        check("result held", bus.result, e);
        check("idle alu_a", bus.alu_a, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen_done;

        vecs[0] = '{MD_MUL,  64'd7, 64'd6, 64'd42, 1'b0};
        vecs[1] = '{MD_MUL,  64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
        vecs[2] = '{MD_MUL,  64'h1234_5678, 64'h1_0000, 64'h1234_5678_0000, 1'b0};
        vecs[3] = '{MD_DIVU, 64'd100, 64'd7, 64'd14, 1'b0};
        vecs[4] = '{MD_REMU, 64'd100, 64'd7, 64'd2, 1'b0};
        vecs[5] = '{MD_DIVU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 1'b0};
        vecs[6] = '{MD_REMU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 1'b0};
        vecs[7] = '{MD_DIVU, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
        vecs[8] = '{2'b11,   64'd9, 64'd3, 64'd0, 1'b1};
        vecs[9] = '{MD_REMU, 64'd5, 64'd0, 64'd5, 1'b1};

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = MD_MUL;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        check("reset busy", {63'd0, bus.busy}, 64'd0);
        check("reset done", {63'd0, bus.done}, 64'd0);
        check("reset result", bus.result, 64'd0);
        check("reset alu_a", bus.alu_a, 64'd0);
        check("reset alu_b", bus.alu_b, 64'd0);
        check("reset alu_ctrl", {60'd0, bus.alu_ctrl}, {60'd0, ALU_ADD});
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].short_op, -1);

        // Competing request mid-run must not disturb the MUL in flight
        run_op(MD_MUL, 64'd7, 64'd6, 64'd42, 1'b0, 10);

        // Reset during iteration 30 aborts the operation silently
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = MD_MUL;
        bus.a     = 64'd11;
        bus.b     = 64'd13;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort busy", {63'd0, bus.busy}, 64'd0);
        check("abort done", {63'd0, bus.done}, 64'd0);
        check("abort result", bus.result, 64'd0);
        check("abort alu_b", bus.alu_b, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (bus.done) seen_done = 1'b1;
        end
        check("no done after abort", {63'd0, seen_done}, 64'd0);

        run_op(MD_MUL, 64'd3, 64'd5, 64'd15, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
